// File: rtl/ups_pkg.sv
// Shared types and default parameter values for the UPS power manager.
package ups_pkg;

    // Operating states; the numeric values are exported on state_dbg.
    typedef enum logic [2:0] {
        OFF       = 3'd0,
        MAINS     = 3'd1,
        BATTERY   = 3'd2,
        SHDN_WAIT = 3'd3
    } ups_state_t;

    localparam int N_OUT_DEF        = 3;
    localparam int BAT_W_DEF        = 4;
    localparam int TICK_DIV_DEF     = 4;
    localparam int LOW_THR_DEF      = 3;
    localparam int RESTART_THR_DEF  = 6;
    localparam int SHED_STEP_DEF    = 4;
    localparam int SHDN_TIMEOUT_DEF = 16;
    localparam int DEB_CYC_DEF      = 3;
    localparam int FAIL_W_DEF       = 4;

endpackage

// File: rtl/ups_mains_debounce.sv
// Mains-sense conditioning: 2-flop synchroniser, optionally followed by a
// debounce filter. Build option: define UPS_DEBOUNCE_EN to enable the filter.
module ups_mains_debounce
    import ups_pkg::*;
#(
    parameter int DEB_CYC = DEB_CYC_DEF
) (
    input  logic clk_2,
    input  logic reset,
    input  logic mains_in,
    output logic mains_ok
);

    logic r_sync1;
    logic r_sync2;

    // Two-stage synchroniser for the asynchronous mains sense input.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= mains_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef UPS_DEBOUNCE_EN
    localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic             r_ok;
    logic [CNT_W-1:0] r_cnt;

    // Accept a new mains level only after DEB_CYC consecutive disagreeing cycles.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            r_ok  <= 1'b0;
            r_cnt <= '0;
        end else if (r_sync2 != r_ok) begin
            if (r_cnt == CNT_LAST) begin
                r_ok  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign mains_ok = r_ok;
`else
    // Without the filter the synchronised level is used directly; DEB_CYC
    // has no effect in this build.
    assign mains_ok = (DEB_CYC >= 0) ? r_sync2 : 1'b0;
`endif

endmodule

// File: rtl/ups_power_manager.sv
// UPS power manager: battery charge tracking, mains/battery switching,
// prioritised outlet shedding and host shutdown handshake.
// Build option: UPS_DEBOUNCE_EN adds a debounce filter on the mains sense.
module ups_power_manager
    import ups_pkg::*;
#(
    parameter int N_OUT        = N_OUT_DEF,
    parameter int BAT_W        = BAT_W_DEF,
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int LOW_THR      = LOW_THR_DEF,
    parameter int RESTART_THR  = RESTART_THR_DEF,
    parameter int SHED_STEP    = SHED_STEP_DEF,
    parameter int SHDN_TIMEOUT = SHDN_TIMEOUT_DEF,
    parameter int DEB_CYC      = DEB_CYC_DEF,
    parameter int FAIL_W       = FAIL_W_DEF
) (
    input  logic              clk_2,
    input  logic              reset,
    input  logic              mains_in,
    input  logic              shutdown_ack,
    output logic [N_OUT-1:0]  power_out,
    output logic              on_battery,
    output logic              shutdown_req,
    output logic [BAT_W-1:0]  charge,
    output logic [FAIL_W-1:0] fail_count,
    output logic [2:0]        state_dbg
);

    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WAIT_W = (SHDN_TIMEOUT > 1) ? $clog2(SHDN_TIMEOUT) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SHDN_TIMEOUT - 1);
    // Charge comparisons are done one bit wider so +1 cannot wrap.
    localparam logic [BAT_W:0] BAT_MAX_X = {1'b0, {BAT_W{1'b1}}};
    localparam logic [BAT_W:0] LOW_X     = (BAT_W+1)'(LOW_THR);
    localparam logic [BAT_W:0] RESTART_X = (BAT_W+1)'(RESTART_THR);

    ups_state_t        r_state;
    ups_state_t        w_state_next;
    logic [BAT_W-1:0]  r_charge;
    logic [BAT_W-1:0]  w_charge_next;
    logic [FAIL_W-1:0] r_fail;
    logic [FAIL_W-1:0] w_fail_next;
    logic [PRE_W-1:0]  r_presc;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_next;
    logic              w_tick;
    logic              w_mains_ok;
    logic [BAT_W:0]    w_charge_x;
    logic [BAT_W:0]    w_charge_inc;
    logic [N_OUT-1:0]  w_shed;

    ups_mains_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_mains (
        .clk_2    (clk_2),
        .reset    (reset),
        .mains_in (mains_in),
        .mains_ok (w_mains_ok)
    );

    assign w_tick       = (r_presc == PRE_LAST);
    assign w_charge_x   = {1'b0, r_charge};
    assign w_charge_inc = w_charge_x + 1'b1;

    // Free-running charge-step prescaler.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Outlet i stays on battery while charge >= LOW_THR + i*SHED_STEP;
    // thresholds above the battery range can never be met.
    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_shed
            localparam int THR = LOW_THR + gi * SHED_STEP;
            if (THR <= (2 ** BAT_W) - 1) begin : g_reach
                assign w_shed[gi] = (w_charge_x >= (BAT_W+1)'(THR));
            end else begin : g_never
                assign w_shed[gi] = 1'b0;
            end
        end
    endgenerate

    // Charge step on each tick, chosen by the state before any transition.
    always_comb begin
        w_charge_next = r_charge;
        if (w_tick) begin
            case (r_state)
                OFF, MAINS: begin
                    if (w_mains_ok && (w_charge_inc <= BAT_MAX_X)) begin
                        w_charge_next = w_charge_inc[BAT_W-1:0];
                    end
                end
                BATTERY, SHDN_WAIT: begin
                    if (w_charge_x != '0) begin
                        w_charge_next = r_charge - 1'b1;
                    end
                end
                default: w_charge_next = r_charge;
            endcase
        end
    end

    // State register plus charge, failure count and shutdown wait counter.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            r_state  <= OFF;
            r_charge <= '0;
            r_fail   <= '0;
            r_wait   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_charge <= w_charge_next;
            r_fail   <= w_fail_next;
            r_wait   <= w_wait_next;
        end
    end

    // Next-state logic and output decode.
    always_comb begin
        w_state_next = r_state;
        w_fail_next  = r_fail;
        w_wait_next  = '0;
        power_out    = '0;
        on_battery   = 1'b0;
        shutdown_req = 1'b0;
        case (r_state)
            OFF: begin
                if (w_mains_ok && (w_charge_x >= RESTART_X)) begin
                    w_state_next = MAINS;
                end
            end
            MAINS: begin
                power_out = '1;
                if (!w_mains_ok) begin
                    w_state_next = BATTERY;
                    if (r_fail != '1) begin
                        w_fail_next = r_fail + 1'b1;
                    end
                end
            end
            BATTERY: begin
                power_out  = w_shed;
                on_battery = 1'b1;
                // Mains returning takes priority over a low battery.
                if (w_mains_ok) begin
                    w_state_next = MAINS;
                end else if (w_charge_x < LOW_X) begin
                    w_state_next = SHDN_WAIT;
                end
            end
            SHDN_WAIT: begin
                power_out    = N_OUT'(1);
                on_battery   = 1'b1;
                shutdown_req = 1'b1;
                w_wait_next  = r_wait + 1'b1;
                // Once requested, shutdown always completes even if mains returns.
                if (shutdown_ack || (r_wait == WAIT_LAST)) begin
                    w_state_next = OFF;
                end
            end
            default: w_state_next = OFF;
        endcase
    end

    assign charge     = r_charge;
    assign fail_count = r_fail;
    assign state_dbg  = r_state;

endmodule
